// File: rtl/ahb_arbiter_if.sv
// Bundle of the arbiter's request/burst-tracking inputs and grant outputs.
// The slave modport is the arbiter's view; the master modport is the bus side.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic [2:0]             hburst;
  logic                   hready;
  logic [1:0]             hresp;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [MW-1:0]          hmaster;
  logic                   hmastlock;

  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready, hresp,
    output hgrant, hmaster, hmastlock
  );

  modport master (
    output hbusreq, hlock, htrans, hburst, hready, hresp,
    input  hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with burst-boundary and locked-transfer protection;
// the bus parks on DEFAULT_MASTER when nobody requests.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input logic          hclk_i,
  input logic          hreset_i,
  ahb_arbiter_if.slave bus_if
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [MW-1:0] DEF_IDX   = MW'(DEFAULT_MASTER);

  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [MW-1:0]          gidx_q, gidx_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [MW-1:0]          ptr_q, ptr_d;
  logic [4:0]             cnt_q, cnt_d;

  logic                   rearb_s;
  logic [MW:0]            pick_s;
  logic                   fixed_s;
  logic                   pending_s;
  logic                   err_first_s;

  function automatic logic [4:0] burst_last(input logic [2:0] hburst);
    logic [4:0] res;
    case (hburst[2:1])
      2'b01:   res = 5'd3;
      2'b10:   res = 5'd7;
      2'b11:   res = 5'd15;
      default: res = 5'd0;
    endcase
    return res;
  endfunction

  // Returns {found, index} of the first requester after ptr, wrapping.
  function automatic logic [MW:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                          input logic [MW-1:0] ptr);
    logic [MW:0] res;
    int          idx;
    res = {(MW+1){1'b0}};
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(ptr) + k) % NUM_MASTERS;
      if (!res[MW] && req[idx]) begin
        res = {1'b1, MW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MW-1:0] idx);
    logic [NUM_MASTERS-1:0] res;
    res = {NUM_MASTERS{1'b0}};
    res[idx] = 1'b1;
    return res;
  endfunction

  // Beat counter: tracks remaining beats of a fixed-length burst.
  always_comb begin
    cnt_d = cnt_q;
    if (bus_if.hready) begin
      case (bus_if.htrans)
        TRANS_NONSEQ: cnt_d = burst_last(bus_if.hburst);
        TRANS_SEQ:    cnt_d = (cnt_q != 5'd0) ? (cnt_q - 5'd1) : cnt_q;
        default:      cnt_d = cnt_q;
      endcase
    end else if (bus_if.hresp != RESP_OKAY) begin
      cnt_d = 5'd0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Re-arbitration decision. While a granted master has not yet taken the
  // address phase, HTRANS still belongs to the old owner and must not re-arbitrate.
  always_comb begin
    fixed_s     = (bus_if.hburst[2:1] != 2'b00);
    pending_s   = (gidx_q != hmaster_q);
    err_first_s = (bus_if.hresp != RESP_OKAY) && !bus_if.hready;
    rearb_s     = 1'b0;
    if (!pending_s && !bus_if.hlock[hmaster_q] && !hmastlock_q) begin
      rearb_s = (bus_if.htrans == TRANS_IDLE)
             || (!bus_if.hbusreq[hmaster_q] && (!fixed_s || (cnt_q == 5'd0)))
             || (fixed_s && (cnt_q == 5'd1) && (bus_if.htrans == TRANS_SEQ) && bus_if.hready)
             || ((bus_if.hburst == BURST_SINGLE) && (bus_if.htrans == TRANS_NONSEQ) && bus_if.hready)
             || err_first_s;
    end else begin
      rearb_s = 1'b0;
    end
  end

  // Winner selection and grant/owner next state.
  always_comb begin
    pick_s      = rr_pick(bus_if.hbusreq, ptr_q);
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    if (rearb_s) begin
      if (pick_s[MW]) begin
        gidx_d = pick_s[MW-1:0];
        ptr_d  = pick_s[MW-1:0];
      end else begin
        gidx_d = DEF_IDX;
        ptr_d  = ptr_q;
      end
    end else begin
      gidx_d = gidx_q;
      ptr_d  = ptr_q;
    end
    hgrant_d = onehot(gidx_d);
    if (bus_if.hready) begin
      hmaster_d   = gidx_q;
      hmastlock_d = bus_if.hlock[gidx_q];
    end else begin
      hmaster_d   = hmaster_q;
      hmastlock_d = hmastlock_q;
    end
  end

  // State registers.
  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      hgrant_q    <= onehot(DEF_IDX);
      gidx_q      <= DEF_IDX;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
      ptr_q       <= DEF_IDX;
      cnt_q       <= 5'd0;
    end else begin
      hgrant_q    <= hgrant_d;
      gidx_q      <= gidx_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus_if.hgrant    = hgrant_q;
  assign bus_if.hmaster   = hmaster_q;
  assign bus_if.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed, table-driven bench for ahb_arbiter with hand-written multi-cycle sequences.
module tb_ahb_arbiter;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] B_SNG  = 3'b000;
  localparam logic [2:0] B_INC4 = 3'b011;
  localparam logic [2:0] B_INC8 = 3'b101;
  localparam logic [2:0] B_I16  = 3'b111;
  localparam logic [1:0] R_OK   = 2'b00;
  localparam logic [1:0] R_RTY  = 2'b10;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [1:0] resp;
    logic [3:0] exp_grant;
    logic [1:0] exp_master;
    logic       exp_lock;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl [24];

  ahb_arbiter_if #(.NUM_MASTERS(4)) bus_if ();

  ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .hclk_i   (clk),
    .hreset_i (rst),
    .bus_if   (bus_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] g, input logic [1:0] m, input logic l);
    chk({nm, " hgrant"}, 32'(bus_if.hgrant), 32'(g));
    chk({nm, " hmaster"}, 32'(bus_if.hmaster), 32'(m));
    chk({nm, " hmastlock"}, 32'(bus_if.hmastlock), 32'(l));
    chk({nm, " onehot"}, 32'($onehot(bus_if.hgrant)), 32'd1);
  endtask

  // Drive one cycle of inputs, clock once, check the registered outputs.
  task automatic step(input string nm, input logic [3:0] req, input logic [3:0] lock,
                      input logic [1:0] trans, input logic [2:0] burst, input logic ready,
                      input logic [1:0] resp, input logic [3:0] g, input logic [1:0] m,
                      input logic l);
    bus_if.hbusreq = req;
    bus_if.hlock   = lock;
    bus_if.htrans  = trans;
    bus_if.hburst  = burst;
    bus_if.hready  = ready;
    bus_if.hresp   = resp;
    @(posedge clk);
    #1;
    chk_out(nm, g, m, l);
  endtask

  initial begin
    // Round robin over masters 1 and 2.
    tbl[0]  = '{4'b0110, 4'b0000, T_IDLE, B_SNG,  1'b1, R_OK, 4'b0010, 2'd0, 1'b0};
    tbl[1]  = '{4'b0110, 4'b0000, T_IDLE, B_SNG,  1'b1, R_OK, 4'b0010, 2'd1, 1'b0};
    tbl[2]  = '{4'b0110, 4'b0000, T_NSEQ, B_SNG,  1'b1, R_OK, 4'b0100, 2'd1, 1'b0};
    tbl[3]  = '{4'b0110, 4'b0000, T_IDLE, B_SNG,  1'b1, R_OK, 4'b0100, 2'd2, 1'b0};
    tbl[4]  = '{4'b0110, 4'b0000, T_NSEQ, B_SNG,  1'b1, R_OK, 4'b0010, 2'd2, 1'b0};
    tbl[5]  = '{4'b0110, 4'b0000, T_IDLE, B_SNG,  1'b1, R_OK, 4'b0010, 2'd1, 1'b0};
    tbl[6]  = '{4'b0100, 4'b0000, T_IDLE, B_SNG,  1'b1, R_OK, 4'b0100, 2'd1, 1'b0};
    tbl[7]  = '{4'b1100, 4'b0000, T_IDLE, B_SNG,  1'b1, R_OK, 4'b0100, 2'd2, 1'b0};
    // Master 2 INCR8 while master 3 waits.
    tbl[8]  = '{4'b1100, 4'b0000, T_NSEQ, B_INC8, 1'b1, R_OK, 4'b0100, 2'd2, 1'b0};
    for (int i = 9; i < 15; i++)
      tbl[i] = '{4'b1100, 4'b0000, T_SEQ, B_INC8, 1'b1, R_OK, 4'b0100, 2'd2, 1'b0};
    tbl[15] = '{4'b1100, 4'b0000, T_SEQ,  B_INC8, 1'b1, R_OK, 4'b1000, 2'd2, 1'b0};
    tbl[16] = '{4'b1100, 4'b0000, T_IDLE, B_SNG,  1'b1, R_OK, 4'b1000, 2'd3, 1'b0};
    // Master 1 locked across two SINGLEs, then one more transfer.
    tbl[17] = '{4'b0010, 4'b0010, T_IDLE, B_SNG,  1'b1, R_OK, 4'b0010, 2'd3, 1'b0};
    tbl[18] = '{4'b1110, 4'b0010, T_IDLE, B_SNG,  1'b1, R_OK, 4'b0010, 2'd1, 1'b1};
    tbl[19] = '{4'b1110, 4'b0010, T_NSEQ, B_SNG,  1'b1, R_OK, 4'b0010, 2'd1, 1'b1};
    tbl[20] = '{4'b1110, 4'b0010, T_NSEQ, B_SNG,  1'b1, R_OK, 4'b0010, 2'd1, 1'b1};
    tbl[21] = '{4'b1110, 4'b0000, T_NSEQ, B_SNG,  1'b1, R_OK, 4'b0010, 2'd1, 1'b0};
    tbl[22] = '{4'b1100, 4'b0000, T_IDLE, B_SNG,  1'b1, R_OK, 4'b0100, 2'd1, 1'b0};
    tbl[23] = '{4'b1100, 4'b0000, T_IDLE, B_SNG,  1'b1, R_OK, 4'b0100, 2'd2, 1'b0};

    bus_if.hbusreq = 4'b0000;
    bus_if.hlock   = 4'b0000;
    bus_if.htrans  = T_IDLE;
    bus_if.hburst  = B_SNG;
    bus_if.hready  = 1'b1;
    bus_if.hresp   = R_OK;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 4'b0001, 2'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++)
      step("park", 4'b0000, 4'b0000, T_IDLE, B_SNG, 1'b1, R_OK, 4'b0001, 2'd0, 1'b0);

    for (int i = 0; i < 24; i++)
      step($sformatf("vec%0d", i), tbl[i].req, tbl[i].lock, tbl[i].trans, tbl[i].burst,
           tbl[i].ready, tbl[i].resp, tbl[i].exp_grant, tbl[i].exp_master, tbl[i].exp_lock);

    // Master 2 INCR4 hit by RETRY; grant moves during a 3-cycle HREADY=0 stretch.
    step("rty_nseq", 4'b1100, 4'b0000, T_NSEQ, B_INC4, 1'b1, R_OK,  4'b0100, 2'd2, 1'b0);
    step("rty_seq",  4'b1100, 4'b0000, T_SEQ,  B_INC4, 1'b1, R_OK,  4'b0100, 2'd2, 1'b0);
    step("rty_1st",  4'b1100, 4'b0000, T_SEQ,  B_INC4, 1'b0, R_RTY, 4'b1000, 2'd2, 1'b0);
    step("stall_a",  4'b1100, 4'b0000, T_SEQ,  B_INC4, 1'b0, R_OK,  4'b1000, 2'd2, 1'b0);
    step("stall_b",  4'b1100, 4'b0000, T_SEQ,  B_INC4, 1'b0, R_OK,  4'b1000, 2'd2, 1'b0);
    step("handover", 4'b1100, 4'b0000, T_IDLE, B_SNG,  1'b1, R_OK,  4'b1000, 2'd3, 1'b0);

    // Master 3 INCR16 interrupted by an asynchronous reset pulse.
    step("i16_nseq", 4'b1000, 4'b0000, T_NSEQ, B_I16, 1'b1, R_OK, 4'b1000, 2'd3, 1'b0);
    step("i16_seq",  4'b1000, 4'b0000, T_SEQ,  B_I16, 1'b1, R_OK, 4'b1000, 2'd3, 1'b0);
    #1 rst = 1'b1;
    #1 chk_out("async_rst", 4'b0001, 2'd0, 1'b0);
    #1 rst = 1'b0;
    step("post_rst_arb", 4'b0100, 4'b0000, T_IDLE, B_SNG, 1'b1, R_OK, 4'b0100, 2'd0, 1'b0);
    step("post_rst_own", 4'b0100, 4'b0000, T_IDLE, B_SNG, 1'b1, R_OK, 4'b0100, 2'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
